cpu_phase_seq: RTL
==================

# cpu_phase_seq

Parametrised phase sequencer for the BPF CPU core. It replaces fixed bench-driven stage clocking (IF/ID/AL/EX) with a synthesizable one-hot stage-enable generator. It adds configurable phase count, reset stretching, stall, single-step, halt-at-boundary, an instruction limit, and cycle/instruction counters. It sits between the top-level clock/reset and the `cpu` core, driving its per-stage enables and core reset.

## Interface

Parameters:
- NPHASE, 4, phases per instruction (≥2); oPHASE[0]=IF, [1]=ID, [2]=AL, [3]=EX, extra phases appended.
- RST_HOLD, 2, cycles oRST_CORE stays high after iRST deasserts (≥1).
- CNT_W, 32, width of cycle and instruction counters.
- MAX_INSN, 0, automatic halt after this many instructions; 0 = unlimited.

Ports:
- iCLK  in  1  single clock; all state on rising edge.
- iRST  in  1  asynchronous, active-low reset.
- iRUN  in  1  level; free-running execution enable.
- iSTEP  in  1  single-cycle pulse; execute one instruction from IDLE.
- iSTALL  in  1  level; hold current phase.
- iHALT  in  1  halt request; takes effect at the next instruction boundary.
- oPHASE  out  NPHASE  one-hot stage enable; all-zero outside RUN.
- oRST_CORE  out  1  registered core reset, active-high.
- oINSN_DONE  out  1  high in the last-phase cycle when that phase advances.
- oBUSY  out  1  high in RUN.
- oHALTED  out  1  high in HALTED.
- oINSN_CNT  out  CNT_W  completed instructions.
- oCYC_CNT  out  CNT_W  cycles spent in RUN, stalls included.

## Operation

- States: HOLD, IDLE, RUN, HALTED.
- Reset (iRST=0), asynchronous:
  - state=HOLD, hold counter=0, phase=0.
  - oRST_CORE=1, oPHASE=0, oINSN_DONE=0, oBUSY=0, oHALTED=0, counters=0.
  - Internal flags halt_pend=0 and step_mode=0.
- HOLD:
  - Hold counter increments each cycle after iRST=1.
  - When it reaches RST_HOLD, go to IDLE; oRST_CORE=0 from that cycle on.
  - iRUN and iSTEP are ignored in HOLD.
- IDLE:
  - If iRUN=1, go to RUN with step_mode=0.
  - Otherwise, if iSTEP=1, go to RUN with step_mode=1.
  - In both cases phase is loaded with one-hot bit 0.
- RUN:
  - Phase register is one-hot and always drives oPHASE.
  - iSTALL=1: phase holds, oCYC_CNT still increments.
  - iSTALL=0: phase rotates left by one.
  - iHALT=1 in any RUN cycle sets halt_pend, including a stalled cycle or the final phase.
- Instruction boundary (last phase with iSTALL=0):
  - oINSN_DONE=1 and oINSN_CNT increments.
  - Next state, first match wins:
    - HALTED if halt_pend or iHALT, or if MAX_INSN≠0 and the new count equals MAX_INSN.
    - Else IDLE if step_mode or iRUN=0.
    - Else stay in RUN with phase=bit 0.
- iRUN deasserted mid-instruction: the instruction completes, then IDLE.
- iSTEP pulses outside IDLE are ignored.
- HALTED:
  - oPHASE=0, oHALTED=1, counters frozen.
  - Left only via iRST.
- Counters saturate at all-ones; no wrap-around.
- The phase register is never zero or multi-hot in RUN. Any illegal encoding is forced to bit 0.

## Timing

- iRST rising to oRST_CORE falling: RST_HOLD rising edges.
- Start latency: oPHASE[0] asserts on the first edge after iRUN/iSTEP is sampled high in IDLE.
- Unstalled instruction: exactly NPHASE cycles. Each stalled cycle adds one.
- Back-to-back instructions in RUN: no bubble; oPHASE[NPHASE-1] is followed directly by oPHASE[0].
- oINSN_DONE is combinational from state/phase/iSTALL, one cycle wide per instruction.
- oINSN_CNT and oCYC_CNT are registered and updated on the edge ending the counted cycle.
- HALTED entered on the edge ending the last phase; oHALTED is high that next cycle with oPHASE=0.
- Asynchronous reset mid-instruction forces all outputs to their reset values immediately, without waiting for a clock edge.

## Test plan

- Reset release (RST_HOLD=2): iRST low 3 cycles, then high -> oRST_CORE=1 for exactly 2 edges then 0; oPHASE=0; counters 0; iRUN=1 during HOLD has no effect.
- Free run (NPHASE=4, MAX_INSN=6, iRUN=1):
  - oPHASE sequence 0001,0010,0100,1000 repeated, no gaps.
  - oINSN_DONE every 4th cycle.
  - After 24 cycles: oHALTED=1, oINSN_CNT=6, oCYC_CNT=24.
- Stall: iSTALL=1 for 3 cycles while oPHASE=0010 -> 0010 held 4 cycles; first oINSN_DONE at cycle 7; oCYC_CNT=7, oINSN_CNT=1.
- Single-step: iRUN=0, one iSTEP pulse -> exactly one 4-phase sequence, then IDLE, oINSN_CNT=1; a second iSTEP pulse during that sequence is ignored.
- Halt at boundary: iHALT pulsed during phase 2 of instruction 3 (MAX_INSN=0) -> instruction 3 completes, oHALTED=1, oINSN_CNT=3, oPHASE=0 thereafter.
- Asynchronous reset mid-run: iRST low between edges while oPHASE=0100 -> immediately oPHASE=0, oRST_CORE=1, counters 0; after release, HOLD lasts RST_HOLD cycles again.

Source files
------------

// File: rtl/cpu_phase_seq_if.sv
// Control/status bundle between the phase sequencer and whoever drives it.
//
// Signalling contract: every i* level is sampled on the rising clock edge.
// No back-pressure exists. oINSN_DONE acts as the "valid" for one completed
// instruction and lasts exactly one cycle. oINSN_CNT and oCYC_CNT are only
// meaningful when oRST_CORE is low. oSTATE exposes the sequencer FSM
// (0=HOLD, 1=IDLE, 2=RUN, 3=HALTED) for observation.
interface cpu_phase_seq_if #(
    parameter int NPHASE = 4,
    parameter int CNT_W  = 32
);
    logic              iRUN;
    logic              iSTEP;
    logic              iSTALL;
    logic              iHALT;
    logic [NPHASE-1:0] oPHASE;
    logic              oRST_CORE;
    logic              oINSN_DONE;
    logic              oBUSY;
    logic              oHALTED;
    logic [CNT_W-1:0]  oINSN_CNT;
    logic [CNT_W-1:0]  oCYC_CNT;
    logic [1:0]        oSTATE;

    modport master (
        output iRUN, iSTEP, iSTALL, iHALT,
        input  oPHASE, oRST_CORE, oINSN_DONE, oBUSY, oHALTED,
        input  oINSN_CNT, oCYC_CNT, oSTATE
    );

    modport slave (
        input  iRUN, iSTEP, iSTALL, iHALT,
        output oPHASE, oRST_CORE, oINSN_DONE, oBUSY, oHALTED,
        output oINSN_CNT, oCYC_CNT, oSTATE
    );
endinterface

// File: rtl/cpu_phase_seq.sv
// One-hot stage-enable generator for the BPF CPU core. It stretches the core
// reset, then steps IF/ID/AL/EX (plus any extra phases) under run, step, stall
// and halt control. It also keeps saturating instruction and cycle counters.
module cpu_phase_seq #(
    parameter int NPHASE   = 4,
    parameter int RST_HOLD = 2,
    parameter int CNT_W    = 32,
    parameter int MAX_INSN = 0
) (
    input  logic            iCLK,
    input  logic            iRST,
    cpu_phase_seq_if.slave  bus
);
    localparam logic [1:0] S_HOLD   = 2'd0;
    localparam logic [1:0] S_IDLE   = 2'd1;
    localparam logic [1:0] S_RUN    = 2'd2;
    localparam logic [1:0] S_HALTED = 2'd3;

    localparam int HW = $clog2(RST_HOLD + 1);

    logic [1:0]        r_state;
    logic [HW-1:0]     r_hold_cnt;
    logic [NPHASE-1:0] r_phase;
    logic              r_rst_core;
    logic              r_halt_pend;
    logic              r_step_mode;
    logic [CNT_W-1:0]  r_insn_cnt;
    logic [CNT_W-1:0]  r_cyc_cnt;

    logic              w_phase_legal;
    logic [NPHASE-1:0] w_phase;
    logic [NPHASE-1:0] w_phase_rot;
    logic              w_in_run;
    logic              w_insn_done;
    logic [CNT_W-1:0]  w_insn_next;
    logic [CNT_W-1:0]  w_cyc_next;
    logic              w_limit_hit;
    logic              w_halt_now;

    // A zero or multi-hot phase register falls back to the first phase, so RUN
    // never presents an illegal enable pattern to the core.
    assign w_phase_legal = (r_phase != '0) && ((r_phase & (r_phase - NPHASE'(1))) == '0);
    assign w_phase       = w_phase_legal ? r_phase : NPHASE'(1);
    assign w_phase_rot   = {w_phase[NPHASE-2:0], w_phase[NPHASE-1]};

    assign w_in_run    = (r_state == S_RUN);
    assign w_insn_done = w_in_run && w_phase[NPHASE-1] && !bus.iSTALL;

    // Both counters stop at all-ones rather than wrapping.
    assign w_insn_next = (r_insn_cnt == '1) ? r_insn_cnt : r_insn_cnt + CNT_W'(1);
    assign w_cyc_next  = (r_cyc_cnt  == '1) ? r_cyc_cnt  : r_cyc_cnt  + CNT_W'(1);

    assign w_limit_hit = (MAX_INSN != 0) && (w_insn_next == CNT_W'(MAX_INSN));
    assign w_halt_now  = r_halt_pend || bus.iHALT || w_limit_hit;

    assign bus.oPHASE     = w_in_run ? w_phase : '0;
    assign bus.oRST_CORE  = r_rst_core;
    assign bus.oINSN_DONE = w_insn_done;
    assign bus.oBUSY      = w_in_run;
    assign bus.oHALTED    = (r_state == S_HALTED);
    assign bus.oINSN_CNT  = r_insn_cnt;
    assign bus.oCYC_CNT   = r_cyc_cnt;
    assign bus.oSTATE     = r_state;

    // Sequencer FSM: reset stretch, idle wait, phase rotation and halt capture.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            r_state     <= S_HOLD;
            r_hold_cnt  <= '0;
            r_phase     <= '0;
            r_rst_core  <= 1'b1;
            r_halt_pend <= 1'b0;
            r_step_mode <= 1'b0;
            r_insn_cnt  <= '0;
            r_cyc_cnt   <= '0;
        end else begin
            case (r_state)
                S_HOLD: begin
                    r_hold_cnt <= r_hold_cnt + HW'(1);
                    if (r_hold_cnt == HW'(RST_HOLD - 1)) begin
                        r_state    <= S_IDLE;
                        r_rst_core <= 1'b0;
                    end
                end
                S_IDLE: begin
                    if (bus.iRUN) begin
                        r_state     <= S_RUN;
                        r_step_mode <= 1'b0;
                        r_phase     <= NPHASE'(1);
                    end else if (bus.iSTEP) begin
                        r_state     <= S_RUN;
                        r_step_mode <= 1'b1;
                        r_phase     <= NPHASE'(1);
                    end
                end
                S_RUN: begin
                    r_cyc_cnt <= w_cyc_next;
                    if (w_insn_done) begin
                        r_insn_cnt <= w_insn_next;
                        r_phase    <= NPHASE'(1);
                        if (w_halt_now) begin
                            r_state <= S_HALTED;
                        end else if (r_step_mode || !bus.iRUN) begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        if (bus.iHALT) begin
                            r_halt_pend <= 1'b1;
                        end
                        r_phase <= bus.iSTALL ? w_phase : w_phase_rot;
                    end
                end
                S_HALTED: begin
                    r_state <= S_HALTED;
                end
            endcase
        end
    end
endmodule
